// File: rtl/uart_loader_xfer.sv
// rtl/uart_loader_xfer.sv - record loader with per-record checksum and frame-buffer dumper over byte streams
module uart_loader_xfer #(
    parameter int REC_BYTES  = 18,
    parameter int CNT_BYTES  = 3,
    parameter int PIX_BYTES  = 3,
    parameter int TIME_BYTES = 3,
    parameter int FB_WORDS   = 65536,
    parameter int ADDR_W     = 24,
    localparam int FB_AW     = $clog2(FB_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_en,
    input  logic                    dump_en,
    input  logic                    done_drawing,
    input  logic [8*TIME_BYTES-1:0] fill_time,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic                    rec_we,
    output logic [ADDR_W-1:0]       rec_addr,
    output logic [8*REC_BYTES-1:0]  rec_data,
    output logic                    fb_rd,
    output logic [FB_AW-1:0]        fb_addr,
    input  logic [8*PIX_BYTES-1:0]  fb_rdata,
    output logic                    sys_rst,
    output logic                    load_done,
    output logic                    load_err,
    output logic                    dump_done
);

    localparam int CW     = 8 * CNT_BYTES;
    localparam int RW     = 8 * REC_BYTES;
    localparam int TW     = 8 * TIME_BYTES;
    localparam int PW     = 8 * PIX_BYTES;
    localparam int LB_MAX = (REC_BYTES > CNT_BYTES) ? REC_BYTES : CNT_BYTES;
    localparam int LBW    = $clog2(LB_MAX + 1);
    localparam int DB_MAX = (TIME_BYTES > PIX_BYTES) ? TIME_BYTES : PIX_BYTES;
    localparam int DBW    = $clog2(DB_MAX + 1);

    typedef enum logic [2:0] {L_IDLE, L_HDR, L_REC, L_CHK, L_WRITE, L_DONE} l_state_t;
    typedef enum logic [2:0] {D_IDLE, D_TIME, D_RD, D_LD, D_SEND, D_DONE} d_state_t;

    l_state_t       l_state, l_next;
    logic           load_en_q, load_start, l_abort, l_bump;
    logic [LBW-1:0] l_cnt;
    logic [CW-1:0]  n_reg, n_shift, rec_cnt;
    logic [7:0]     sum;
    logic           chk_pend, hdr_last, rec_last, last_rec;

    assign sys_rst    = rst | load_en;
    assign load_start = load_en & ~load_en_q;
    assign n_shift    = {rx_data, n_reg[CW-1:8]};
    assign hdr_last   = (l_cnt == LBW'(CNT_BYTES - 1));
    assign rec_last   = (l_cnt == LBW'(REC_BYTES - 1));
    assign last_rec   = ((rec_cnt + CW'(1)) == n_reg);
    assign load_done  = (l_state == L_DONE);
    assign rec_we     = (l_state == L_WRITE);

    always_comb begin
        l_next  = l_state;
        l_bump  = 1'b0;
        l_abort = 1'b0;
        case (l_state)
            L_IDLE:  if (load_start) l_next = L_HDR;
            L_HDR:   if (rx_valid && hdr_last) l_next = (n_shift == '0) ? L_DONE : L_REC;
            L_REC:   if (rx_valid && rec_last) l_next = L_CHK;
            // Checksum byte is captured first, then resolved on the following cycle
            L_CHK: begin
                if (chk_pend) begin
                    if (sum == 8'd0) begin
                        l_next = L_WRITE;
                    end else begin
                        l_bump = 1'b1;
                        l_next = last_rec ? L_DONE : L_REC;
                    end
                end
            end
            L_WRITE: begin
                l_bump = 1'b1;
                l_next = last_rec ? L_DONE : L_REC;
            end
            L_DONE:  if (load_start) l_next = L_HDR;
            default: l_next = L_IDLE;
        endcase
        if (!load_en && (l_state inside {L_HDR, L_REC, L_CHK, L_WRITE})) begin
            l_abort = 1'b1;
            l_bump  = 1'b0;
            l_next  = L_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_state   <= L_IDLE;
            load_en_q <= load_en;
            l_cnt     <= '0;
            n_reg     <= '0;
            rec_cnt   <= '0;
            sum       <= '0;
            chk_pend  <= 1'b0;
            rec_addr  <= '0;
            rec_data  <= '0;
            load_err  <= 1'b0;
        end else begin
            l_state   <= l_next;
            load_en_q <= load_en;
            if ((l_state == L_IDLE || l_state == L_DONE) && load_start) begin
                l_cnt    <= '0;
                n_reg    <= '0;
                rec_cnt  <= '0;
                sum      <= '0;
                chk_pend <= 1'b0;
                rec_addr <= '0;
                load_err <= 1'b0;
            end else if (l_abort) begin
                l_cnt    <= '0;
                sum      <= '0;
                chk_pend <= 1'b0;
            end else begin
                case (l_state)
                    L_HDR: if (rx_valid) begin
                        n_reg <= n_shift;
                        l_cnt <= hdr_last ? '0 : l_cnt + LBW'(1);
                    end
                    L_REC: if (rx_valid) begin
                        rec_data <= {rx_data, rec_data[RW-1:8]};
                        sum      <= sum + rx_data;
                        l_cnt    <= rec_last ? '0 : l_cnt + LBW'(1);
                    end
                    L_CHK: begin
                        if (chk_pend) begin
                            chk_pend <= 1'b0;
                            sum      <= '0;
                            if (sum != 8'd0) load_err <= 1'b1;
                        end else if (rx_valid) begin
                            sum      <= sum + rx_data;
                            chk_pend <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (l_bump) begin
                    rec_addr <= rec_addr + ADDR_W'(1);
                    rec_cnt  <= rec_cnt + CW'(1);
                end
            end
        end
    end

    d_state_t       d_state, d_next;
    logic [TW-1:0]  time_sr;
    logic [PW-1:0]  pix_sr;
    logic [DBW-1:0] d_cnt;
    logic           xfer, d_start, fb_last, time_last, pix_last;

    assign xfer      = tx_ready & ((d_state == D_TIME) || (d_state == D_SEND));
    assign d_start   = dump_en & done_drawing & ~load_en;
    assign fb_last   = (fb_addr == FB_AW'(FB_WORDS - 1));
    assign time_last = (d_cnt == DBW'(TIME_BYTES - 1));
    assign pix_last  = (d_cnt == DBW'(PIX_BYTES - 1));

    always_comb begin
        d_next    = d_state;
        tx_valid  = 1'b0;
        tx_data   = 8'd0;
        fb_rd     = 1'b0;
        dump_done = 1'b0;
        case (d_state)
            D_IDLE: if (d_start) d_next = D_TIME;
            D_TIME: begin
                tx_valid = 1'b1;
                tx_data  = time_sr[TW-1 -: 8];
                if (xfer && time_last) d_next = D_RD;
            end
            D_RD: begin
                fb_rd  = 1'b1;
                d_next = D_LD;
            end
            D_LD:   d_next = D_SEND;
            D_SEND: begin
                tx_valid = 1'b1;
                tx_data  = pix_sr[PW-1 -: 8];
                if (xfer && pix_last) d_next = fb_last ? D_DONE : D_RD;
            end
            D_DONE: begin
                dump_done = 1'b1;
                if (!dump_en) d_next = D_IDLE;
            end
            default: d_next = D_IDLE;
        endcase
        // A cancelled dump never truncates a byte already offered to the UART
        if (!dump_en && ((d_state == D_RD) || (d_state == D_LD) || xfer)) d_next = D_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_state <= D_IDLE;
            time_sr <= '0;
            pix_sr  <= '0;
            d_cnt   <= '0;
            fb_addr <= '0;
        end else begin
            d_state <= d_next;
            case (d_state)
                D_IDLE: if (d_start) begin
                    time_sr <= fill_time;
                    d_cnt   <= '0;
                end
                D_TIME: if (xfer) begin
                    time_sr <= time_sr << 8;
                    d_cnt   <= time_last ? '0 : d_cnt + DBW'(1);
                end
                D_LD: begin
                    pix_sr <= fb_rdata;
                    d_cnt  <= '0;
                end
                D_SEND: if (xfer) begin
                    pix_sr <= pix_sr << 8;
                    d_cnt  <= pix_last ? '0 : d_cnt + DBW'(1);
                    if (pix_last && !fb_last) fb_addr <= fb_addr + FB_AW'(1);
                end
                default: ;
            endcase
            if (d_next == D_IDLE) begin
                fb_addr <= '0;
                d_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_loader_xfer.sv
// tb/tb_uart_loader_xfer.sv - directed bench for uart_loader_xfer load, dump, abort and reset paths
module tb_uart_loader_xfer;

    localparam int REC_BYTES = 18;
    localparam int ADDR_W    = 24;
    localparam int FB_WORDS  = 4;
    localparam int FB_AW     = 2;
    localparam int RW        = 8 * REC_BYTES;

    logic              clk = 1'b0;
    logic              rst, load_en, dump_en, done_drawing, rx_valid, tx_ready;
    logic              tx_valid, rec_we, fb_rd, sys_rst, load_done, load_err, dump_done;
    logic [23:0]       fill_time, fb_rdata;
    logic [7:0]        rx_data, tx_data;
    logic [ADDR_W-1:0] rec_addr;
    logic [RW-1:0]     rec_data;
    logic [FB_AW-1:0]  fb_addr;

    int n_tests = 0;
    int n_fail  = 0;

    uart_loader_xfer #(
        .REC_BYTES(REC_BYTES), .CNT_BYTES(3), .PIX_BYTES(3), .TIME_BYTES(3),
        .FB_WORDS(FB_WORDS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .dump_en(dump_en),
        .done_drawing(done_drawing), .fill_time(fill_time),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rec_we(rec_we), .rec_addr(rec_addr), .rec_data(rec_data),
        .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
        .sys_rst(sys_rst), .load_done(load_done), .load_err(load_err), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (fb_rd) fb_rdata <= 24'h112233 + 24'(fb_addr);

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [RW-1:0]     wr_data_q[$];
    always @(negedge clk) if (rec_we) begin
        wr_addr_q.push_back(rec_addr);
        wr_data_q.push_back(rec_data);
    end

    logic tx_rand = 1'b0, tx_force = 1'b0, rnd_ready = 1'b0, coll_on = 1'b0;
    logic stalled = 1'b0;
    logic [7:0] held = 8'd0;
    logic [7:0] coll_q[$];
    assign tx_ready = tx_rand ? rnd_ready : tx_force;

    always @(negedge clk) begin
        logic rdy;
        rnd_ready = 1'($urandom_range(0, 1));
        rdy = tx_rand ? rnd_ready : tx_force;
        if (coll_on) begin
            if (stalled) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, held);
            end
            if (tx_valid && rdy) coll_q.push_back(tx_data);
            stalled = tx_valid && !rdy;
            held    = tx_data;
        end
    end

    typedef struct {
        int         n;
        logic [7:0] bad;
        logic       exp_err;
        int         exp_writes;
    } load_vec_t;
    load_vec_t     lv[4];
    logic [RW-1:0] exp_rec[8];

    function automatic logic [7:0] payload(input int v, input int i, input int j);
        return 8'(v * 37 + i * 19 + j * 7 + 1);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        @(negedge clk); rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic start_load();
        @(negedge clk); load_en = 1'b0;
        @(negedge clk); load_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_load(input int v);
        logic [23:0]   nn;
        logic [7:0]    b, s;
        logic [RW-1:0] r;
        int k, to;
        nn = 24'(lv[v].n);
        wr_addr_q.delete(); wr_data_q.delete();
        start_load();
        check($sformatf("v%0d load_done_cleared", v), load_done, 0);
        send_byte(nn[7:0]); send_byte(nn[15:8]); send_byte(nn[23:16]);
        for (int i = 0; i < lv[v].n; i++) begin
            s = 8'd0; r = '0;
            for (int j = 0; j < REC_BYTES; j++) begin
                b = payload(v, i, j);
                r[8*j +: 8] = b;
                s = s + b;
                send_byte(b);
            end
            exp_rec[i] = r;
            send_byte(8'(8'd0 - s + {7'd0, lv[v].bad[i]}));
        end
        to = 0;
        while (!load_done && to < 50) begin @(negedge clk); to++; end
        check($sformatf("v%0d load_done", v), load_done, 1);
        check($sformatf("v%0d load_err", v), load_err, lv[v].exp_err);
        check($sformatf("v%0d write_count", v), wr_addr_q.size(), lv[v].exp_writes);
        k = 0;
        for (int i = 0; i < lv[v].n; i++) begin
            if (!lv[v].bad[i]) begin
                if (k < wr_addr_q.size()) begin
                    check($sformatf("v%0d rec_addr", v), wr_addr_q[k], i);
                    check($sformatf("v%0d rec_data", v), wr_data_q[k], exp_rec[i]);
                end
                k++;
            end
        end
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!tx_valid && k < 50) begin @(negedge clk); k++; end
        check(name, tx_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx_valid"}, tx_valid, 0);
        check({tag, " tx_data"}, tx_data, 0);
        check({tag, " rec_we"}, rec_we, 0);
        check({tag, " rec_addr"}, rec_addr, 0);
        check({tag, " rec_data"}, rec_data, 0);
        check({tag, " fb_rd"}, fb_rd, 0);
        check({tag, " fb_addr"}, fb_addr, 0);
        check({tag, " sys_rst"}, sys_rst, 1);
        check({tag, " load_done"}, load_done, 0);
        check({tag, " load_err"}, load_err, 0);
        check({tag, " dump_done"}, dump_done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [7:0] exp_stream[15];
    logic [7:0] exp_lead[4];
    int to;

    initial begin
        lv[0] = '{3, 8'b0000_0010, 1'b1, 2};
        lv[1] = '{2, 8'b0000_0000, 1'b0, 2};
        lv[2] = '{1, 8'b0000_0001, 1'b1, 0};
        lv[3] = '{4, 8'b0000_1000, 1'b1, 3};
        exp_stream = '{8'h0A, 8'h0B, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h34,
                       8'h11, 8'h22, 8'h35, 8'h11, 8'h22, 8'h36};
        exp_lead   = '{8'h0A, 8'h0B, 8'h0C, 8'h11};

        rst = 1'b1; load_en = 1'b0; dump_en = 1'b0; done_drawing = 1'b0;
        fill_time = 24'h0A0B0C; rx_valid = 1'b0; rx_data = 8'd0; fb_rdata = 24'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle sys_rst", sys_rst, 0);

        for (int v = 0; v < 4; v++) run_load(v);

        // Empty load: done exactly one cycle after the last header byte
        wr_addr_q.delete(); wr_data_q.delete();
        start_load();
        send_byte(8'h00); send_byte(8'h00);
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h00;
        check("empty done_before", load_done, 0);
        @(negedge clk); rx_valid = 1'b0;
        check("empty done_after", load_done, 1);
        repeat (5) @(negedge clk);
        check("empty writes", wr_addr_q.size(), 0);
        check("empty rec_addr", rec_addr, 0);

        // Load abort after 10 record bytes
        wr_addr_q.delete(); wr_data_q.delete();
        start_load();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        for (int j = 0; j < 10; j++) send_byte(payload(9, 0, j));
        @(negedge clk); load_en = 1'b0;
        @(negedge clk);
        check("abort sys_rst", sys_rst, 0);
        for (int j = 10; j < REC_BYTES + 1; j++) send_byte(payload(9, 0, j));
        repeat (5) @(negedge clk);
        check("abort writes", wr_addr_q.size(), 0);
        check("abort load_done", load_done, 0);

        // Dump with random back-pressure
        done_drawing = 1'b1; tx_rand = 1'b1; coll_q.delete(); coll_on = 1'b1;
        @(negedge clk); dump_en = 1'b1;
        to = 0;
        while (!dump_done && to < 3000) begin @(negedge clk); to++; end
        coll_on = 1'b0; tx_rand = 1'b0;
        check("dump done", dump_done, 1);
        check("dump byte_count", coll_q.size(), 15);
        for (int i = 0; i < 15; i++)
            if (i < coll_q.size()) check($sformatf("dump byte%0d", i), coll_q[i], exp_stream[i]);
        check("dump last fb_addr", fb_addr, 3);
        dump_en = 1'b0;
        @(negedge clk);
        check("dump release done", dump_done, 0);
        check("dump release fb_addr", fb_addr, 0);

        // Dump abort in the middle of a pixel
        tx_force = 1'b0;
        @(negedge clk); dump_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid($sformatf("abort lead_valid%0d", i));
            check($sformatf("abort lead_byte%0d", i), tx_data, exp_lead[i]);
            tx_force = 1'b1;
            @(negedge clk); tx_force = 1'b0;
        end
        wait_valid("abort mid_valid");
        check("abort mid_data", tx_data, 8'h22);
        dump_en = 1'b0;
        @(negedge clk);
        check("abort held_valid", tx_valid, 1);
        check("abort held_data", tx_data, 8'h22);
        tx_force = 1'b1;
        @(negedge clk); tx_force = 1'b0;
        check("abort tx_valid_low", tx_valid, 0);
        check("abort fb_addr", fb_addr, 0);
        repeat (3) @(negedge clk);
        check("abort stays_idle", tx_valid, 0);

        // Reset with the dump stalled in D_SEND and a load in L_REC
        tx_force = 1'b1;
        @(negedge clk); dump_en = 1'b1;
        to = 0;
        while (!fb_rd && to < 50) begin @(negedge clk); to++; end
        tx_force = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rstmid send_valid", tx_valid, 1);
        load_en = 1'b1;
        @(negedge clk);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        for (int j = 0; j < 5; j++) send_byte(payload(7, 0, j));
        check("rstmid rec_data_top", rec_data[RW-1 -: 8], payload(7, 0, 4));
        check("rstmid still_valid", tx_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rstmid");
        dump_en = 1'b0; load_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst sys_rst", sys_rst, 0);
        check("post_rst tx_valid", tx_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
